multi_sync_debounce: RTL and testbench
======================================

# multi_sync_debounce

Parametrised multi-channel input conditioner for asynchronous signals such as buttons, switches and external strobes. Each channel passes through a configurable-depth flip-flop synchronizer and then a stable-count debounce filter. Each channel produces a clean level plus single-cycle rise and fall pulses. The block sits between board-level inputs and any FSM that consumes them, replacing per-signal two-flop synchronizers.

## Interface
Parameters:
- N_CH, default 4: number of independent channels.
- SYNC_STAGES, default 2: synchronizer flop depth per channel. Legal values are 2 or more.
- DB_CYCLES, default 4: consecutive cycles a new synchronized value must hold before it is accepted. Legal values are 1 or more; 1 means no filtering.
- INIT_VAL, default 0: reset value (one bit, applied to all channels) of the synchronizer flops and the debounced level.

Ports:
- clk, input, 1: sole clock.
- rst, input, 1: reset, asynchronous and active-high.
- async_in, input, N_CH: raw asynchronous inputs.
- sync_out, output, N_CH: debounced, synchronized level.
- rise, output, N_CH: one-cycle pulse when sync_out goes 0→1.
- fall, output, N_CH: one-cycle pulse when sync_out goes 1→0.

## Operation
- Channels are fully independent. Nothing is shared between channels except clk and rst.
- Synchronizer: a shift chain of SYNC_STAGES flops per channel. Let s be the last stage.
- Debounce state per channel: stable level db (drives sync_out) and counter cnt, width $clog2(DB_CYCLES+1).
- Each clock edge, per channel:
  - s == db: cnt←0.
  - s != db and cnt < DB_CYCLES-1: cnt←cnt+1.
  - s != db and cnt == DB_CYCLES-1: db←s and cnt←0. Pulse rise (if s=1) or fall (if s=0) in the same cycle db changes.
- rise and fall are registered. They are high for exactly one cycle per accepted transition and never both high on one channel.
- A glitch on s shorter than DB_CYCLES cycles resets cnt, with no output change and no pulse.
- With DB_CYCLES=1, db follows s one edge later, and every change of s produces a pulse.
- Reset:
  - All synchronizer flops go to INIT_VAL, and sync_out = {N_CH{INIT_VAL}}.
  - cnt = 0, rise = 0, fall = 0.
  - No pulse is generated on reset release, even if async_in differs from INIT_VAL. A transition then shows up only through the normal debounce path.
- Reset asserted mid-count: the count is discarded immediately (asynchronous). After release, counting restarts from 0.
- Elaboration error if SYNC_STAGES < 2, DB_CYCLES < 1, or N_CH < 1.

## Timing
- async_in is sampled on posedge clk. s reflects the new value SYNC_STAGES edges after the first sampling edge.
- sync_out, rise and fall update DB_CYCLES edges after s changes. Total latency is SYNC_STAGES + DB_CYCLES edges from the first sampling edge.
- Defaults: a stable input change appears on sync_out and rise/fall 6 edges after it is first sampled.
- Minimum accepted pulse width on async_in is DB_CYCLES cycles of stable s. Shorter pulses are always rejected.
- Sustained toggling faster than DB_CYCLES never changes the output.
- Only the first synchronizer stage may go metastable. Downstream logic reads s only.

## Structure
- Shared package sync_pkg holds:
  - the default constants SYNC_STAGES_DEF=2 and DB_CYCLES_DEF=4;
  - the helper function cnt_width(DB_CYCLES).
- Sub-module sync_debounce_ch is one channel: synchronizer chain, debounce counter and edge pulses. The top level instantiates N_CH of them in a generate loop and concatenates the outputs.
- The synchronizer chain is a flat register vector with shift on clk. No combinational logic sits between the chain stages.

## Test plan
- Reset with INIT_VAL=0 and async_in=4'b1010, then release: sync_out=0, rise=fall=0 during reset. After release, channels 1 and 3 reach sync_out=1 with one rise pulse each, 6 edges after the first sampling edge.
- Clean step of channel 0 from 0 to 1, held 20 cycles: rise[0] high exactly 1 cycle, 6 edges after the first sampling edge, with sync_out[0]=1 in that same cycle. fall stays 0.
- Glitch on channel 2 of 3 cycles, then back to 0: sync_out[2] stays 0 and no pulses occur. Repeat with a 4-cycle high: the rise pulse appears, and when the signal returns low, a fall pulse follows 4 cycles after s goes low.
- All 4 channels toggle together with differing widths (2, 4, 5 and 8 cycles): only the channels with width ≥ 4 pulse, each independently.
- rst asserted when cnt=2, then released with the input still changed: outputs immediately return to INIT_VAL, and there is no pulse from the pre-reset count.
- Parameter sweep SYNC_STAGES in {2, 3} × DB_CYCLES in {1, 4}: latency equals SYNC_STAGES+DB_CYCLES edges. With DB_CYCLES=1, a 1-cycle input pulse yields rise then fall on consecutive cycles.

Source files
------------

// File: rtl/sync_pkg.sv
// Shared defaults and sizing helper for the synchronizer/debounce input conditioners.
// Pure constants and functions; no logic, no latency, no backpressure.
package sync_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int DB_CYCLES_DEF   = 4;

  // Counter must be able to hold 0..DB_CYCLES.
  function automatic int cnt_width(input int db_cycles);
    return (db_cycles < 1) ? 1 : $clog2(db_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_debounce_ch.sv
// One channel: flop synchronizer, stable-count debounce filter, registered rise/fall pulses.
// Latency SYNC_STAGES + DB_CYCLES edges from first sampling edge; free-running, no backpressure.
module sync_debounce_ch
  import sync_pkg::*;
#(
  parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int   DB_CYCLES   = DB_CYCLES_DEF,
  parameter logic INIT_VAL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  localparam int            CW       = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("sync_debounce_ch: SYNC_STAGES must be >= 2");
    end
    if (DB_CYCLES < 1) begin : g_bad_db
      $error("sync_debounce_ch: DB_CYCLES must be >= 1");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CW-1:0]          cnt;

  // Plain shift chain; only sync_q[0] may go metastable, so nothing reads it but the next stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{INIT_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      sync_out <= INIT_VAL;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == sync_out) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        sync_out <= s;
        cnt      <= '0;
        rise     <= s;
        fall     <= ~s;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/multi_sync_debounce.sv
// N_CH independent synchronize-and-debounce channels sharing only clk and rst.
// Latency SYNC_STAGES + DB_CYCLES edges per channel; free-running, no backpressure.
module multi_sync_debounce
  import sync_pkg::*;
#(
  parameter int   N_CH        = 4,
  parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int   DB_CYCLES   = DB_CYCLES_DEF,
  parameter logic INIT_VAL    = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] async_in,
  output logic [N_CH-1:0] sync_out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall
);

  generate
    if (N_CH < 1) begin : g_bad_nch
      $error("multi_sync_debounce: N_CH must be >= 1");
    end

    for (genvar g_ch = 0; g_ch < N_CH; g_ch++) begin : g_ch_inst
      sync_debounce_ch #(
        .SYNC_STAGES(SYNC_STAGES),
        .DB_CYCLES  (DB_CYCLES),
        .INIT_VAL   (INIT_VAL)
      ) u_ch (
        .clk     (clk),
        .rst     (rst),
        .async_in(async_in[g_ch]),
        .sync_out(sync_out[g_ch]),
        .rise    (rise[g_ch]),
        .fall    (fall[g_ch])
      );
    end
  endgenerate

endmodule

// File: tb/tb_multi_sync_debounce.sv
// Bench for multi_sync_debounce: table-driven pulse vectors with an event scoreboard,
// hand sequences for reset and toggling, and a SYNC_STAGES x DB_CYCLES latency sweep.
module tb_multi_sync_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] async_in;
  wire  [3:0] sync_out, rise, fall;

  logic [3:0] sw_in;
  wire  [3:0] sw_out, sw_rise, sw_fall;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  logic [3:0] exp_level = 4'b0000;

  typedef struct {
    int cyc;
    int ch;
    bit is_rise;
  } ev_t;
  ev_t sb[$];

  typedef struct {
    int         width[4];
    logic [3:0] exp_pulse;
    string      name;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multi_sync_debounce #(.N_CH(4), .SYNC_STAGES(2), .DB_CYCLES(4), .INIT_VAL(1'b0)) dut (
    .clk(clk), .rst(rst), .async_in(async_in), .sync_out(sync_out), .rise(rise), .fall(fall)
  );

  multi_sync_debounce #(.N_CH(1), .SYNC_STAGES(2), .DB_CYCLES(1), .INIT_VAL(1'b0)) u_sw0 (
    .clk(clk), .rst(rst), .async_in(sw_in[0]), .sync_out(sw_out[0]), .rise(sw_rise[0]), .fall(sw_fall[0])
  );
  multi_sync_debounce #(.N_CH(1), .SYNC_STAGES(3), .DB_CYCLES(1), .INIT_VAL(1'b0)) u_sw1 (
    .clk(clk), .rst(rst), .async_in(sw_in[1]), .sync_out(sw_out[1]), .rise(sw_rise[1]), .fall(sw_fall[1])
  );
  multi_sync_debounce #(.N_CH(1), .SYNC_STAGES(3), .DB_CYCLES(4), .INIT_VAL(1'b0)) u_sw2 (
    .clk(clk), .rst(rst), .async_in(sw_in[2]), .sync_out(sw_out[2]), .rise(sw_rise[2]), .fall(sw_fall[2])
  );
  multi_sync_debounce #(.N_CH(1), .SYNC_STAGES(2), .DB_CYCLES(4), .INIT_VAL(1'b0)) u_sw3 (
    .clk(clk), .rst(rst), .async_in(sw_in[3]), .sync_out(sw_out[3]), .rise(sw_rise[3]), .fall(sw_fall[3])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_ev(input int c, input int ch, input bit r);
    ev_t e;
    e.cyc     = c;
    e.ch      = ch;
    e.is_rise = r;
    sb.push_back(e);
  endfunction

  function automatic void set_vec(input int idx, input int w0, input int w1, input int w2,
                                  input int w3, input logic [3:0] ep, input string nm);
    vecs[idx].width[0]  = w0;
    vecs[idx].width[1]  = w1;
    vecs[idx].width[2]  = w2;
    vecs[idx].width[3]  = w3;
    vecs[idx].exp_pulse = ep;
    vecs[idx].name      = nm;
  endfunction

  // Scoreboard monitor: events due this cycle become the expected pulses and level.
  always @(negedge clk) begin
    logic [3:0] er, ef;
    int         i;
    if (mon_en) begin
      er = 4'b0000;
      ef = 4'b0000;
      i  = 0;
      while (i < sb.size()) begin
        if (sb[i].cyc <= cyc) begin
          if (sb[i].is_rise) er[sb[i].ch] = 1'b1;
          else               ef[sb[i].ch] = 1'b1;
          sb.delete(i);
        end else begin
          i++;
        end
      end
      exp_level = (exp_level | er) & ~ef;
      check($sformatf("rise@%0d", cyc), rise, er);
      check($sformatf("fall@%0d", cyc), fall, ef);
      check($sformatf("sync_out@%0d", cyc), sync_out, exp_level);
    end
  end

  initial begin
    int k, maxw;
    int lat_exp[4];
    int pr_exp[4];
    int pf_exp[4];
    int pc_exp[4];
    int got_r[4];
    int got_f[4];
    int n_r[4];
    int n_f[4];
    logic [3:0] lvl_at_rise;

    set_vec(0, 20, 0, 0, 0, 4'b0001, "step_ch0");
    set_vec(1,  0, 0, 3, 0, 4'b0000, "glitch3_ch2");
    set_vec(2,  0, 0, 4, 0, 4'b0100, "pulse4_ch2");
    set_vec(3,  2, 4, 5, 8, 4'b1110, "mixed_2_4_5_8");
    set_vec(4,  1, 1, 1, 1, 4'b0000, "all_1cyc");
    set_vec(5,  6, 3, 7, 2, 4'b0101, "mixed_6_3_7_2");

    // Reset with inputs already differing from INIT_VAL.
    rst      = 1'b1;
    async_in = 4'b1010;
    sw_in    = 4'b0000;
    repeat (3) tick();
    check("reset_sync_out", sync_out, 4'b0000);
    check("reset_rise", rise, 4'b0000);
    check("reset_fall", fall, 4'b0000);
    rst = 1'b0;
    exp_level = 4'b0000;
    push_ev(cyc + 6, 1, 1'b1);
    push_ev(cyc + 6, 3, 1'b1);
    mon_en = 1'b1;
    repeat (10) tick();
    async_in = 4'b0000;
    push_ev(cyc + 6, 1, 1'b0);
    push_ev(cyc + 6, 3, 1'b0);
    repeat (12) tick();

    for (int v = 0; v < 6; v++) begin
      k    = cyc;
      maxw = 0;
      for (int c = 0; c < 4; c++) begin
        if (vecs[v].width[c] > maxw) maxw = vecs[v].width[c];
        if (vecs[v].exp_pulse[c]) begin
          push_ev(k + 6, c, 1'b1);
          push_ev(k + vecs[v].width[c] + 6, c, 1'b0);
        end
        async_in[c] = (vecs[v].width[c] > 0);
      end
      for (int j = 1; j <= maxw; j++) begin
        tick();
        for (int c = 0; c < 4; c++)
          if (vecs[v].width[c] == j) async_in[c] = 1'b0;
      end
      repeat (12) tick();
    end

    // Sustained toggling faster than the filter: never accepted.
    for (int t = 0; t < 6; t++) begin
      async_in[1] = 1'b1;
      repeat (3) tick();
      async_in[1] = 1'b0;
      repeat (3) tick();
    end
    repeat (10) tick();

    // Reset mid-count while another channel holds a high level.
    async_in[3] = 1'b1;
    push_ev(cyc + 6, 3, 1'b1);
    repeat (10) tick();
    async_in[0] = 1'b1;
    repeat (4) tick();
    check("sb_empty_before_rst", sb.size(), 0);
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    check("midrst_sync_out", sync_out, 4'b0000);
    check("midrst_rise", rise, 4'b0000);
    check("midrst_fall", fall, 4'b0000);
    repeat (2) tick();
    rst = 1'b0;
    exp_level = 4'b0000;
    push_ev(cyc + 6, 0, 1'b1);
    push_ev(cyc + 6, 3, 1'b1);
    mon_en = 1'b1;
    repeat (10) tick();
    async_in = 4'b0000;
    push_ev(cyc + 6, 0, 1'b0);
    push_ev(cyc + 6, 3, 1'b0);
    repeat (12) tick();

    // Parameter sweep: (S,D) = (2,1) (3,1) (3,4) (2,4).
    lat_exp = '{3, 4, 7, 6};
    pr_exp  = '{3, 4, -1, -1};
    pf_exp  = '{4, 5, -1, -1};
    pc_exp  = '{1, 1, 0, 0};
    lvl_at_rise = 4'b0000;
    for (int i = 0; i < 4; i++) got_r[i] = -1;
    k = cyc;
    sw_in = 4'b1111;
    repeat (12) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++)
        if (sw_rise[i] === 1'b1 && got_r[i] < 0) begin
          got_r[i]       = cyc - k;
          lvl_at_rise[i] = sw_out[i];
        end
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sweep%0d_latency", i), got_r[i], lat_exp[i]);
      check($sformatf("sweep%0d_level_at_rise", i), lvl_at_rise[i], 1'b1);
    end
    tick();
    sw_in = 4'b0000;
    repeat (15) tick();

    for (int i = 0; i < 4; i++) begin
      got_r[i] = -1;
      got_f[i] = -1;
      n_r[i]   = 0;
      n_f[i]   = 0;
    end
    k = cyc;
    sw_in = 4'b1111;
    tick();
    sw_in = 4'b0000;
    repeat (12) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (sw_rise[i] === 1'b1) begin
          n_r[i]++;
          if (got_r[i] < 0) got_r[i] = cyc - k;
        end
        if (sw_fall[i] === 1'b1) begin
          n_f[i]++;
          if (got_f[i] < 0) got_f[i] = cyc - k;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pulse1_%0d_rise_at", i), got_r[i], pr_exp[i]);
      check($sformatf("pulse1_%0d_fall_at", i), got_f[i], pf_exp[i]);
      check($sformatf("pulse1_%0d_rise_cnt", i), n_r[i], pc_exp[i]);
      check($sformatf("pulse1_%0d_fall_cnt", i), n_f[i], pc_exp[i]);
    end

    repeat (4) tick();
    mon_en = 1'b0;
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
